dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: the slave end of the CPU MEM-stage load/store interface.
//  - Accepts one word read or write request at a time over a valid/ready handshake.
//  - Services the request after a fixed, programmable latency.
//  - Returns a response (read data or write ack, plus error flag) over a second
//    valid/ready handshake.
//  - Replaces the zero-latency data Memory; lets the pipeline be tested against
//    slow memory and back-pressure.
// PARAMETERS
//  ADDR_WIDTH  10  word-address bits; array depth = 2**ADDR_WIDTH words
//  DATA_WIDTH  32  data word width
//  LATENCY     2   cycles from request accept to first resp_valid; legal range 1..15
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  req_valid   in   1           request present
//  req_ready   out  1           responder can accept a request
//  req_write   in   1           1 = store, 0 = load
//  req_addr    in   32          byte address
//  req_wdata   in   DATA_WIDTH  store data
//  resp_valid  out  1           response present
//  resp_ready  in   1           requester takes response
//  resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
//  resp_err    out  1           misaligned or out-of-range address
//  busy        out  1           state != IDLE
// BEHAVIOUR
//  - One clock domain, synchronous active-high reset.
//  - On reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//    busy=0, latency counter=0, whole array cleared to 0.
//  - FSM states: IDLE, WAIT, RESP.
//    - IDLE: req_ready=1. On req_valid at edge T, latch write, addr, wdata and the
//      error check.
//      - LATENCY==1: go to RESP.
//      - Otherwise: go to WAIT with cnt=LATENCY-1.
//    - WAIT: req_ready=0. cnt decrements each cycle; when cnt==1 at an edge, go to RESP.
//    - RESP: resp_valid=1. resp_rdata and resp_err are held stable until
//      resp_valid&resp_ready. On that handshake go to IDLE.
//  - Timing: resp_valid first high in the cycle after edge T+LATENCY-1, i.e.
//    LATENCY cycles after accept.
//  - No request is accepted in RESP, even when resp_ready=1. Peak throughput is one
//    request per LATENCY+1 cycles.
//  - Error: addr[1:0]!=0 or addr[31:2] >= 2**ADDR_WIDTH.
//    - Array is not accessed.
//    - Response has resp_err=1, resp_rdata=0.
//  - Store: array[addr[ADDR_WIDTH+1:2]] <= wdata on the edge entering RESP (commit
//    point). Response carries resp_rdata=0, resp_err=0.
//  - Load: array is read on the edge entering RESP and the value registered into
//    resp_rdata. A load that follows a store to the same word returns the new data.
//  - Input rules:
//    - req_* inputs are ignored while req_ready=0.
//    - Requester must hold req_* stable while req_valid=1 and req_ready=0.
//  - resp_ready is ignored while resp_valid=0.
//  - Reset mid-operation, in WAIT or RESP:
//    - Pending store is discarded, never committed.
//    - Pending response is dropped.
//    - FSM returns to IDLE with the reset values above.
//  - No combinational path from any input to any output; all outputs are registered
//    or decoded from state.
// TESTING
//  1 Reset, LATENCY=2:
//    - reset=1 for 2 cycles -> req_ready=1, resp_valid=0, busy=0, resp_rdata=0.
//  2 Store then load, LATENCY=2:
//    - Store 0xDEADBEEF @0x40 -> resp_valid 2 cycles after accept, resp_err=0,
//      resp_rdata=0.
//    - Then load 0x40 -> resp_rdata=0xDEADBEEF.
//  3 Back-pressure:
//    - Load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable for
//      all 5 cycles, req_ready=0.
//    - resp_ready=1 -> IDLE next cycle.
//  4 Errors:
//    - Load @0x42 -> resp_err=1, resp_rdata=0.
//    - Store @(4<<ADDR_WIDTH) -> resp_err=1.
//    - Then load word 0 -> still 0, array untouched.
//  5 Reset mid-store:
//    - Store 0x12345678 @0x10, assert reset during WAIT.
//    - Then load 0x10 -> 0; no stale resp_valid after reset.
//  6 LATENCY=1 and LATENCY=15 builds:
//    - Back-to-back loads with resp_ready=1 -> accept spacing exactly LATENCY+1
//      cycles; data correct.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder acting as the slave end of the CPU
//                MEM-stage load/store interface. Accepts one word request at a
//                time over a valid/ready handshake, services it after a fixed
//                LATENCY and returns the result over a second valid/ready
//                handshake.
//  Ports       : clock, reset                   - clock / sync active-high reset
//                req_valid/req_ready            - request handshake
//                req_write/req_addr/req_wdata   - request payload (byte address)
//                resp_valid/resp_ready          - response handshake
//                resp_rdata/resp_err            - response payload
//                busy                           - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2      // legal range 1..15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);
    localparam logic       c_LAT_ONE  = (LATENCY == 1);

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_write;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_resp_rdata;
    logic                    r_resp_err;
    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

    logic                    w_high_bits;
    logic                    w_req_err;
    logic [ADDR_WIDTH-1:0]   w_req_idx;
    logic                    w_enter_resp;
    logic                    w_svc_write;
    logic                    w_svc_err;
    logic [ADDR_WIDTH-1:0]   w_svc_idx;
    logic [DATA_WIDTH-1:0]   w_svc_wdata;

    // Out-of-range detection: any set bit above the word index is past the array.
    generate
        if (ADDR_WIDTH < 30) begin : g_range_chk
            assign w_high_bits = |req_addr[31:ADDR_WIDTH+2];
        end else begin : g_no_range_chk
            assign w_high_bits = 1'b0;
        end
    endgenerate

    assign w_req_err = (req_addr[1:0] != 2'b00) | w_high_bits;
    assign w_req_idx = req_addr[ADDR_WIDTH+1:2];

    // The commit/read point is the edge entering RESP. With LATENCY==1 that
    // edge is the accept edge itself, so the live request fields are used;
    // otherwise the fields latched at accept time are used.
    assign w_enter_resp = ((r_state == S_IDLE) && req_valid && c_LAT_ONE) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_svc_write  = (r_state == S_IDLE) ? req_write : r_write;
    assign w_svc_err    = (r_state == S_IDLE) ? w_req_err : r_err;
    assign w_svc_idx    = (r_state == S_IDLE) ? w_req_idx : r_idx;
    assign w_svc_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_err   <= w_req_err;
                        r_idx   <= w_req_idx;
                        r_wdata <= req_wdata;
                        if (c_LAT_ONE) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Erroneous requests never touch the array and report zero data.
            if (w_enter_resp) begin
                if (w_svc_err) begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b1;
                end else if (w_svc_write) begin
                    r_mem[w_svc_idx] <= w_svc_wdata;
                    r_resp_rdata     <= '0;
                    r_resp_err       <= 1'b0;
                end else begin
                    r_resp_rdata <= r_mem[w_svc_idx];
                    r_resp_err   <= 1'b0;
                end
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
